// File: rtl/reg_map_pkg.sv
// reg_map_pkg: shared FSM encoding and flattened-vector helpers for the parametrised register map.
package reg_map_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
    // Bounds for get_slice: DATA_W <= MAX_W and NUM_REGS*DATA_W <= MAX_FLAT.
    localparam int MAX_FLAT = 8192;
    localparam int MAX_W = 64;
    function automatic int rw_bit(input int addr_w);
        return addr_w;
    endfunction
    function automatic logic [MAX_W-1:0] get_slice(input logic [MAX_FLAT-1:0] v, input int i, input int w);
        return MAX_W'(v >> (i * w));
    endfunction
endpackage

// File: rtl/reg_map_cell.sv
// reg_map_cell: one register with bus-over-fabric write priority and a bus write pulse.
module reg_map_cell
    import reg_map_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit RO = 1'b0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_we,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              hw_we,
    input  logic [DATA_W-1:0] hw_wdata,
    output logic [DATA_W-1:0] q,
    output logic              wr_pulse
);
    logic bus_wr;
    assign bus_wr = bus_we && !RO;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
            wr_pulse <= 1'b0;
        end else begin
            q <= bus_wr ? bus_wdata : hw_we ? hw_wdata : q;
            wr_pulse <= bus_wr;
        end
    end
endmodule

// File: rtl/reg_map_param.sv
// reg_map_param: host request FSM, decode, read mux and error response over a bank of reg_map_cell.
module reg_map_param
    import reg_map_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W:0]              req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);
    localparam int RW = rw_bit(ADDR_W);
    state_t state, state_nx;
    logic [ADDR_W:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rd_mux;
    logic err_q, ro_hit, oor, is_wr;
    logic [NUM_REGS-1:0] sel, bus_we;
    // An index that selects no register is out of range.
    always_comb begin
        sel = '0;
        rd_mux = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = addr_q[ADDR_W-1:0] == ADDR_W'(i);
            rd_mux |= sel[i] ? reg_q[i*DATA_W +: DATA_W] : '0;
            ro_hit |= sel[i] & RO_MASK[i];
        end
        is_wr = addr_q[RW];
        oor = ~|sel;
        bus_we = (state == EXEC && is_wr) ? sel : '0;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (req_valid ? EXEC : IDLE) : (state == EXEC) ? RESP : IDLE;
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err = rsp_valid && err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) begin
                addr_q <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == EXEC) begin
                rdata_q <= (is_wr || oor) ? '0 : rd_mux;
                err_q <= oor || (is_wr && ro_hit);
            end
        end
    end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_map_cell #(
            .DATA_W(DATA_W),
            .RO(RO_MASK[i]),
            .RESET_VAL(DATA_W'(get_slice(MAX_FLAT'(RESET_VALS), i, DATA_W)))
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .bus_we(bus_we[i]),
            .bus_wdata(wdata_q),
            .hw_we(hw_we[i]),
            .hw_wdata(hw_wdata[i*DATA_W +: DATA_W]),
            .q(reg_q[i*DATA_W +: DATA_W]),
            .wr_pulse(reg_wr_pulse[i])
        );
    end
endmodule

// File: tb/tb_reg_map_param.sv
// tb_reg_map_param: scoreboard bench with a behavioural register-array model and randomized requests.
module tb_reg_map_param;
    localparam logic [63:0] RV = 64'hF9F8F7F6F5F4F3F2;
    localparam logic [7:0] RO = 8'h01;

    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
    logic req_ready, rsp_valid, rsp_err;
    logic [7:0] req_addr = '0, req_wdata = '0, rsp_rdata, hw_we = '0, reg_wr_pulse;
    logic [63:0] hw_wdata = '0, reg_q;

    reg_map_param #(.DATA_W(8), .ADDR_W(7), .NUM_REGS(8), .RO_MASK(RO), .RESET_VALS(RV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd;
        bit chk_rd;
        logic err;
        logic [7:0] pulse;
        logic [63:0] regs;
        int acc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] mdl[8];
    int checks = 0, errors = 0, nresp = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl[i] = RV[i*8 +: 8];
    endtask

    // Monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid) begin
                nresp++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc - e.acc), 2);
                    chk("rsp_err", rsp_err, e.err);
                    chk("wr_pulse", reg_wr_pulse, e.pulse);
                    chk("reg_q", reg_q, e.regs);
                    if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rd);
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 0);
                chk("idle_pulse", reg_wr_pulse, 0);
            end
        end
    end

    task automatic req(input logic [7:0] a, input logic [7:0] d, input int hold,
                       input bit hw_on, input int hj, input logic [7:0] hv);
        exp_t e;
        int n0, idx;
        bit wr, oor;
        n0 = nresp;
        @(negedge clk);
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        chk("ready_wait", req_ready, 1);
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        e.acc = cyc;
        @(posedge clk);
        #1;
        idx = int'(a[6:0]);
        wr = a[7];
        oor = idx >= 8;
        e.chk_rd = !wr || oor;
        e.rd = (!wr && !oor) ? mdl[idx] : 8'h00;
        e.err = oor || (wr && RO[idx%8]);
        e.pulse = (wr && !e.err) ? 8'(1 << idx) : 8'h00;
        if (hw_on) mdl[hj] = hv;
        if (wr && !e.err) mdl[idx] = d;
        e.regs = pack();
        sb.push_back(e);
        req_valid = hold > 0;
        if (hw_on) begin
            hw_we[hj] = 1'b1;
            hw_wdata[hj*8 +: 8] = hv;
        end
        @(posedge clk);
        #1;
        hw_we = '0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10 && nresp == n0; k++) @(negedge clk);
        chk("rsp_count", 64'(nresp - n0), 1);
    endtask

    task automatic hw_load(input int i, input logic [7:0] v);
        @(negedge clk);
        hw_we[i] = 1'b1;
        hw_wdata[i*8 +: 8] = v;
        @(posedge clk);
        #1;
        hw_we = '0;
        mdl[i] = v;
        chk("hw_load", reg_q, pack());
    endtask

    initial begin
        int n0;
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_reg_q", reg_q, RV);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);

        req(8'h82, 8'hA5, 0, 0, 0, 0);
        req(8'h02, 8'h00, 0, 0, 0, 0);
        req(8'h08, 8'h00, 0, 0, 0, 0);
        req(8'hFF, 8'h12, 0, 0, 0, 0);
        req(8'h80, 8'h55, 0, 0, 0, 0);
        hw_load(0, 8'h33);
        req(8'h83, 8'h11, 0, 1, 3, 8'h99);
        req(8'h05, 8'h00, 0, 1, 5, 8'h44);
        req(8'h05, 8'h00, 0, 0, 0, 0);
        req(8'h03, 8'h00, 2, 0, 0, 0);

        // Abort a write while it is in EXEC.
        n0 = nresp;
        @(negedge clk);
        req_addr = 8'h84;
        req_wdata = 8'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #7;
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        #1;
        chk("midrst_reg_q", reg_q, RV);
        chk("midrst_ready", req_ready, 1);
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", 64'(nresp - n0), 0);
        req(8'h04, 8'h00, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] a;
            a[7] = 1'($urandom);
            a[6:0] = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 11));
            req(a, 8'($urandom), 0, 1'($urandom), $urandom_range(0, 7), 8'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
